// File: rtl/div_pkg.sv
// Shared types and helpers for the shared divider controller: FSM states,
// default sizing and the round-robin grant function.
package div_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_NUM_REQ = 2;
  localparam int MAX_REQ     = 32;
  localparam int MAX_ID_W    = 5;

  typedef enum logic [1:0] {IDLE, ITER, FIX, RESP} state_t;

  typedef struct packed {
    logic                hit;
    logic [MAX_ID_W-1:0] idx;
  } grant_t;

  // First valid requester scanning from ptr upward, wrapping at n.
  function automatic grant_t rr_grant(input logic [MAX_REQ-1:0] vld,
                                      input int unsigned ptr,
                                      input int unsigned n);
    grant_t      g;
    int unsigned k;
    g = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (!g.hit && i < n) begin
        k = (ptr + i) % n;
        if (vld[k]) begin
          g.hit = 1'b1;
          g.idx = k[MAX_ID_W-1:0];
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/div_nr_step.sv
// One non-restoring division iteration: shift {A,Q}, add/subtract M by the
// sign of the old A, shift in the new quotient bit.
module div_nr_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] m_ext;

  assign shifted = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
  assign m_ext   = {1'b0, m};
  assign a_out   = a_in[WIDTH] ? (shifted + m_ext) : (shifted - m_ext);
  assign q_out   = {q_in[WIDTH-2:0], ~a_out[WIDTH]};

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one bit-serial non-restoring divider.
// Optional DIV_SHARE_DZ_FLAG_EN adds rsp_dz, flagging a zero divisor.
module div_share_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_q,
  output logic [WIDTH-1:0]         rsp_r,
`ifdef DIV_SHARE_DZ_FLAG_EN
  output logic                     rsp_dz,
`endif
  output logic                     busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [WIDTH:0]     a_q;
  logic [WIDTH-1:0]   q_q, m_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     a_step;
  logic [WIDTH-1:0]   q_step;
  logic [WIDTH:0]     a_fix;
  logic [MAX_REQ-1:0] vld_ext;
  grant_t             gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               accept;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               last_iter;

  always_comb begin
    vld_ext = '0;
    vld_ext[NUM_REQ-1:0] = req_valid;
  end

  assign gnt    = rr_grant(vld_ext, 32'(rr_ptr), NUM_REQ);
  assign gnt_id = ID_W'(gnt.idx);
  assign accept = (state == IDLE) && gnt.hit;
  assign sel_a  = req_a[gnt_id*WIDTH +: WIDTH];
  assign sel_b  = req_b[gnt_id*WIDTH +: WIDTH];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  div_nr_step #(.WIDTH(WIDTH)) u_step (
    .a_in  (a_q),
    .q_in  (q_q),
    .m     (m_q),
    .a_out (a_step),
    .q_out (q_step)
  );

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  // Final correction brings a negative partial remainder back into [0, M).
  assign a_fix     = a_q[WIDTH] ? (a_q + {1'b0, m_q}) : a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (sel_a == '0 || sel_b == '0) ? RESP : ITER;
      ITER: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      rsp_id <= '0;
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      rsp_q  <= '0;
      rsp_r  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          rsp_id <= gnt_id;
          m_q    <= sel_b;
          q_q    <= sel_a;
          a_q    <= '0;
          cnt_q  <= '0;
          rsp_q  <= '0;
          rsp_r  <= '0;
        end
        ITER: begin
          a_q   <= a_step;
          q_q   <= q_step;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          a_q   <= a_fix;
          rsp_q <= q_q;
          rsp_r <= a_fix[WIDTH-1:0];
        end
        RESP: if (rsp_ready) begin
          rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

`ifdef DIV_SHARE_DZ_FLAG_EN
  logic dz_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dz_q <= 1'b0;
    else if (accept) dz_q <= (sel_b == '0);
  end
  assign rsp_dz = rsp_valid & dz_q;
`endif

endmodule
